// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if -- bundle of requester, shared-ALU and completion signals
// for the alu_arbiter block. The slave modport is the arbiter's view; the
// master modport is the view of the logic surrounding it (requesters + ALU).
interface alu_arbiter_if #(
    parameter int M = 4
);
    // requester side
    logic         req0_valid;
    logic         req1_valid;
    logic [M-1:0] req0_a;
    logic [M-1:0] req0_b;
    logic [M-1:0] req1_a;
    logic [M-1:0] req1_b;
    logic [3:0]   req0_sel;
    logic [3:0]   req1_sel;

    // shared ALU side
    logic [M-1:0] alu_a;
    logic [M-1:0] alu_b;
    logic [3:0]   alu_sel;
    logic [M-1:0] alu_result;
    logic [3:0]   alu_flags;

    // completion / status
    logic         ack0;
    logic         ack1;
    logic [M-1:0] res_out;
    logic [3:0]   res_flags;
    logic         err;
    logic         busy;
    logic [7:0]   op_count;

    modport slave (
        input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
               req0_sel, req1_sel, alu_result, alu_flags,
        output alu_a, alu_b, alu_sel, ack0, ack1, res_out, res_flags,
               err, busy, op_count
    );

    modport master (
        output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
               req0_sel, req1_sel, alu_result, alu_flags,
        input  alu_a, alu_b, alu_sel, ack0, ack1, res_out, res_flags,
               err, busy, op_count
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter -- arbitrates two requesters onto one shared combinational ALU.
// Flow: requests are registered at edge k, the winner is latched into the ALU
// operand registers at edge k+1 (IDLE->EXEC), the ALU result is captured at
// edge k+2 (EXEC->DONE) and the ack is high for the following cycle (DONE).
// Optional build macro: ALU_ARB_FIXED_PRIO_EN -- when defined, ties always go
// to requester 0 and the round-robin pointer is not built.
module alu_arbiter #(
    parameter int M = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    alu_arbiter_if.slave  io_bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Opcodes 0..9 are implemented by the ALU; 10..15 are rejected.
    function automatic logic f_sel_legal(input logic [3:0] sel);
        return (sel <= 4'd9);
    endfunction

    state_t       r_state;
    state_t       w_state_nxt;

    // registered copies of the requester inputs
    logic         r_v0;
    logic         r_v1;
    logic [M-1:0] r_a0;
    logic [M-1:0] r_b0;
    logic [M-1:0] r_a1;
    logic [M-1:0] r_b1;
    logic [3:0]   r_s0;
    logic [3:0]   r_s1;

    // grant bookkeeping
    logic         w_any;
    logic         w_gnt;
    logic         r_gnt;
    logic         r_illegal;
`ifndef ALU_ARB_FIXED_PRIO_EN
    logic         r_last;
`endif

    // winner's operands
    logic [M-1:0] w_win_a;
    logic [M-1:0] w_win_b;
    logic [3:0]   w_win_sel;

    // registered outputs and their next values
    logic [M-1:0] r_alu_a,    w_alu_a_nxt;
    logic [M-1:0] r_alu_b,    w_alu_b_nxt;
    logic [3:0]   r_alu_sel,  w_alu_sel_nxt;
    logic [M-1:0] r_res,      w_res_nxt;
    logic [3:0]   r_flags,    w_flags_nxt;
    logic         r_ack0,     w_ack0_nxt;
    logic         r_ack1,     w_ack1_nxt;
    logic         r_err,      w_err_nxt;
    logic         r_busy,     w_busy_nxt;
    logic [7:0]   r_cnt,      w_cnt_nxt;
    logic         w_gnt_nxt;
    logic         w_illegal_nxt;

    // Register requester inputs. The edge that leaves DONE is exactly the edge
    // at which the granted requester reacts to its ack, so the valids sampled
    // there are stale and are dropped; held requests reappear one edge later.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_v0 <= 1'b0;
            r_v1 <= 1'b0;
            r_a0 <= {M{1'b0}};
            r_b0 <= {M{1'b0}};
            r_a1 <= {M{1'b0}};
            r_b1 <= {M{1'b0}};
            r_s0 <= 4'd0;
            r_s1 <= 4'd0;
        end else begin
            r_v0 <= io_bus.req0_valid && (r_state != ST_DONE);
            r_v1 <= io_bus.req1_valid && (r_state != ST_DONE);
            r_a0 <= io_bus.req0_a;
            r_b0 <= io_bus.req0_b;
            r_a1 <= io_bus.req1_a;
            r_b1 <= io_bus.req1_b;
            r_s0 <= io_bus.req0_sel;
            r_s1 <= io_bus.req1_sel;
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic: IDLE waits for a request, EXEC and DONE last one cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_nxt = ST_EXEC;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_EXEC: w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Pick the winner among registered requests (0 = requester 0, 1 = requester 1).
    always_comb begin
        w_any = r_v0 | r_v1;
`ifdef ALU_ARB_FIXED_PRIO_EN
        if (r_v0) begin
            w_gnt = 1'b0;
        end else begin
            w_gnt = r_v1;
        end
`else
        if (r_v0 && r_v1) begin
            w_gnt = ~r_last;
        end else if (r_v0) begin
            w_gnt = 1'b0;
        end else begin
            w_gnt = r_v1;
        end
`endif
        if (w_gnt) begin
            w_win_a   = r_a1;
            w_win_b   = r_b1;
            w_win_sel = r_s1;
        end else begin
            w_win_a   = r_a0;
            w_win_b   = r_b0;
            w_win_sel = r_s0;
        end
    end

`ifndef ALU_ARB_FIXED_PRIO_EN
    // Round-robin pointer: remembers the last granted requester, starts at 1.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_last <= 1'b1;
        end else if ((r_state == ST_IDLE) && w_any) begin
            r_last <= w_gnt;
        end else begin
            r_last <= r_last;
        end
    end
`endif

    // FSM output logic: next values for every registered output.
    always_comb begin
        w_alu_a_nxt   = r_alu_a;
        w_alu_b_nxt   = r_alu_b;
        w_alu_sel_nxt = r_alu_sel;
        w_res_nxt     = r_res;
        w_flags_nxt   = r_flags;
        w_ack0_nxt    = 1'b0;
        w_ack1_nxt    = 1'b0;
        w_err_nxt     = 1'b0;
        w_busy_nxt    = (w_state_nxt != ST_IDLE);
        w_cnt_nxt     = r_cnt;
        w_gnt_nxt     = r_gnt;
        w_illegal_nxt = r_illegal;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_gnt_nxt     = w_gnt;
                    w_alu_a_nxt   = w_win_a;
                    w_alu_b_nxt   = w_win_b;
                    w_illegal_nxt = ~f_sel_legal(w_win_sel);
                    if (f_sel_legal(w_win_sel)) begin
                        w_alu_sel_nxt = w_win_sel;
                    end else begin
                        w_alu_sel_nxt = 4'd0;
                    end
                end else begin
                    w_gnt_nxt = r_gnt;
                end
            end
            ST_EXEC: begin
                if (r_illegal) begin
                    w_res_nxt   = {M{1'b0}};
                    w_flags_nxt = 4'd0;
                end else begin
                    w_res_nxt   = io_bus.alu_result;
                    w_flags_nxt = io_bus.alu_flags;
                end
                w_ack0_nxt = ~r_gnt;
                w_ack1_nxt = r_gnt;
                w_err_nxt  = r_illegal;
            end
            ST_DONE: begin
                if (r_illegal) begin
                    w_cnt_nxt = r_cnt;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            default: begin
                w_cnt_nxt = r_cnt;
            end
        endcase
    end

    // Output and grant-context registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_alu_a   <= {M{1'b0}};
            r_alu_b   <= {M{1'b0}};
            r_alu_sel <= 4'd0;
            r_res     <= {M{1'b0}};
            r_flags   <= 4'd0;
            r_ack0    <= 1'b0;
            r_ack1    <= 1'b0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
            r_cnt     <= 8'd0;
            r_gnt     <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_alu_a   <= w_alu_a_nxt;
            r_alu_b   <= w_alu_b_nxt;
            r_alu_sel <= w_alu_sel_nxt;
            r_res     <= w_res_nxt;
            r_flags   <= w_flags_nxt;
            r_ack0    <= w_ack0_nxt;
            r_ack1    <= w_ack1_nxt;
            r_err     <= w_err_nxt;
            r_busy    <= w_busy_nxt;
            r_cnt     <= w_cnt_nxt;
            r_gnt     <= w_gnt_nxt;
            r_illegal <= w_illegal_nxt;
        end
    end

    assign io_bus.alu_a     = r_alu_a;
    assign io_bus.alu_b     = r_alu_b;
    assign io_bus.alu_sel   = r_alu_sel;
    assign io_bus.res_out   = r_res;
    assign io_bus.res_flags = r_flags;
    assign io_bus.ack0      = r_ack0;
    assign io_bus.ack1      = r_ack1;
    assign io_bus.err       = r_err;
    assign io_bus.busy      = r_busy;
    assign io_bus.op_count  = r_cnt;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter -- directed self-checking bench for alu_arbiter (M=4).
// The shared ALU is modelled as an adder with {V,N,Z,C} flags.
module tb_alu_arbiter;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    alu_arbiter_if #(.M(4)) bus ();

    alu_arbiter #(.M(4)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    // adder ALU model
    logic [4:0] w_sum;
    assign w_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
    assign bus.alu_result = w_sum[3:0];
    assign bus.alu_flags  = {(bus.alu_a[3] == bus.alu_b[3]) && (w_sum[3] != bus.alu_a[3]),
                             w_sum[3], (w_sum[3:0] == 4'd0), w_sum[4]};

    int n_checks = 0;
    int n_pass   = 0;

    // results of the last run_op
    logic       got_ok;
    int         got_lat;
    logic [3:0] got_res;
    logic [3:0] got_flags;
    logic       got_err;
    logic       got_other;
    logic [3:0] got_alu_a;
    logic [3:0] got_alu_b;
    logic [3:0] got_alu_sel;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation from requester 'who', hold it until ack, then release.
    task automatic run_op(input int who, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] sel, input bit scramble);
        bit seen_busy;
        seen_busy = 1'b0;
        got_ok    = 1'b0;
        got_lat   = -1;
        if (who == 0) begin
            bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_sel = sel;
        end else begin
            bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_sel = sel;
        end
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.busy && !seen_busy) begin
                seen_busy   = 1'b1;
                got_alu_a   = bus.alu_a;
                got_alu_b   = bus.alu_b;
                got_alu_sel = bus.alu_sel;
                if (scramble) begin
                    if (who == 0) begin
                        bus.req0_a = ~a; bus.req0_b = ~b; bus.req0_sel = 4'd14;
                    end else begin
                        bus.req1_a = ~a; bus.req1_b = ~b; bus.req1_sel = 4'd14;
                    end
                end
            end
            if ((who == 0 && bus.ack0) || (who == 1 && bus.ack1)) begin
                got_ok    = 1'b1;
                got_lat   = i;
                got_res   = bus.res_out;
                got_flags = bus.res_flags;
                got_err   = bus.err;
                got_other = (who == 0) ? bus.ack1 : bus.ack0;
                break;
            end
        end
        step();
        if (who == 0) bus.req0_valid = 1'b0;
        else          bus.req1_valid = 1'b0;
    endtask

    initial begin
        int ng;
        int gseq [4];
        int miss;
        int exp_g;

        rst = 1'b1;
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.req0_a = 4'd0; bus.req0_b = 4'd0; bus.req0_sel = 4'd0;
        bus.req1_a = 4'd0; bus.req1_b = 4'd0; bus.req1_sel = 4'd0;
        step();
        step();
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        check("reset_outputs", {1'b0, bus.alu_a, bus.alu_b, bus.alu_sel, bus.res_out, bus.res_flags,
                                bus.ack0, bus.ack1, bus.err, bus.op_count}, 32'd0);
        rst = 1'b0;
        step();

        // basic add from requester 0: 3+5=8, flags V=1 N=1 Z=0 C=0
        run_op(0, 4'd3, 4'd5, 4'd0, 1'b0);
        check("add_acked",   {31'd0, got_ok}, 32'd1);
        check("add_latency", got_lat, 32'd2);
        check("add_alu_a",   {28'd0, got_alu_a}, 32'd3);
        check("add_alu_b",   {28'd0, got_alu_b}, 32'd5);
        check("add_res",     {28'd0, got_res}, 32'd8);
        check("add_flags",   {28'd0, got_flags}, 32'hC);
        check("add_err",     {31'd0, got_err}, 32'd0);
        check("add_other_ack", {31'd0, got_other}, 32'd0);
        check("add_op_count", {24'd0, bus.op_count}, 32'd1);

        // illegal opcode from requester 1
        run_op(1, 4'd7, 4'd7, 4'd12, 1'b0);
        check("ill_acked",   {31'd0, got_ok}, 32'd1);
        check("ill_alu_sel", {28'd0, got_alu_sel}, 32'd0);
        check("ill_err",     {31'd0, got_err}, 32'd1);
        check("ill_res",     {28'd0, got_res}, 32'd0);
        check("ill_flags",   {28'd0, got_flags}, 32'd0);
        check("ill_other_ack", {31'd0, got_other}, 32'd0);
        check("ill_op_count", {24'd0, bus.op_count}, 32'd1);

        // both requesters held valid: 1+1 from req0, 2+2 from req1
        bus.req0_valid = 1'b1; bus.req0_a = 4'd1; bus.req0_b = 4'd1; bus.req0_sel = 4'd2;
        bus.req1_valid = 1'b1; bus.req1_a = 4'd2; bus.req1_b = 4'd2; bus.req1_sel = 4'd3;
        ng = 0;
        for (int k = 0; k < 4; k++) gseq[k] = -1;
        for (int i = 0; i < 40 && ng < 4; i++) begin
            step();
            check("tie_no_overlap", {31'd0, bus.ack0 & bus.ack1}, 32'd0);
            check("tie_ack_only_busy", {31'd0, (bus.ack0 | bus.ack1) & ~bus.busy}, 32'd0);
            if (bus.ack0 | bus.ack1) begin
                gseq[ng] = bus.ack1 ? 1 : 0;
                check("tie_res", {28'd0, bus.res_out}, bus.ack1 ? 32'd4 : 32'd2);
                ng++;
                if (ng == 4) begin
                    bus.req0_valid = 1'b0;
                    bus.req1_valid = 1'b0;
                end
            end
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        step();
        step();
        check("tie_grant_total", ng, 32'd4);
        for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            exp_g = 0;
`else
            exp_g = k % 2;
`endif
            check("tie_grant_order", gseq[k], exp_g);
        end
        check("tie_op_count", {24'd0, bus.op_count}, 32'd5);
        check("tie_idle_after", {31'd0, bus.busy}, 32'd0);

        // reset while in EXEC
        bus.req0_valid = 1'b1; bus.req0_a = 4'd5; bus.req0_b = 4'd6; bus.req0_sel = 4'd0;
        step();
        step();
        check("rst_busy_in_exec", {31'd0, bus.busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_busy_cleared", {31'd0, bus.busy}, 32'd0);
        check("rst_outputs_cleared", {1'b0, bus.alu_a, bus.alu_b, bus.alu_sel, bus.res_out, bus.res_flags,
                                      bus.ack0, bus.ack1, bus.err, bus.op_count}, 32'd0);
        bus.req0_valid = 1'b0;
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("rst_no_ack", {31'd0, bus.ack0 | bus.ack1}, 32'd0);
        end
        run_op(0, 4'd2, 4'd4, 4'd0, 1'b0);
        check("rst_next_acked", {31'd0, got_ok}, 32'd1);
        check("rst_next_latency", got_lat, 32'd2);
        check("rst_next_res", {28'd0, got_res}, 32'd6);
        check("rst_next_op_count", {24'd0, bus.op_count}, 32'd1);

        // operands changed after grant must not affect the result: 9+2=11
        run_op(0, 4'd9, 4'd2, 4'd0, 1'b1);
        check("hold_acked", {31'd0, got_ok}, 32'd1);
        check("hold_res",   {28'd0, got_res}, 32'hB);
        check("hold_flags", {28'd0, got_flags}, 32'h4);
        check("hold_err",   {31'd0, got_err}, 32'd0);
        check("hold_op_count", {24'd0, bus.op_count}, 32'd2);

        // drive op_count from 2 to 255, then wrap
        miss = 0;
        for (int n = 0; n < 253; n++) begin
            run_op(n % 2, 4'(n), 4'd1, 4'(n % 10), 1'b0);
            if (!got_ok) miss++;
        end
        check("wrap_all_acked", miss, 32'd0);
        check("wrap_count_255", {24'd0, bus.op_count}, 32'd255);
        run_op(1, 4'd4, 4'd4, 4'd9, 1'b0);
        check("wrap_last_acked", {31'd0, got_ok}, 32'd1);
        check("wrap_count_0", {24'd0, bus.op_count}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
